// File: rtl/secuenciador_de_notas.sv
// Plays the fixed 25-note "Happy Birthday" melody as a square wave, advancing
// on every level change of cambiar_nota and leaving a one-tick gap after each note.
//   state   | meaning
//   REPOSO  | idle after reset, waiting for iniciar
//   SONANDO | current note sounding, tone generator running
//   PAUSA   | one-tick silent gap after a note
//   FIN     | song finished, waiting for iniciar
module secuenciador_de_notas #(
  parameter int LARGO   = 25,
  parameter bit REPETIR = 1'b0
) (
  input  logic       clk_divisor,
  input  logic       rst_n,
  input  logic       cambiar_nota,
  input  logic       iniciar,
  output logic       parlante,
  output logic [4:0] indice_nota,
  output logic       sonando,
  output logic       fin_cancion
);

  localparam logic [1:0] REPOSO  = 2'd0;
  localparam logic [1:0] SONANDO = 2'd1;
  localparam logic [1:0] PAUSA   = 2'd2;
  localparam logic [1:0] FIN     = 2'd3;

  localparam logic [4:0] ULTIMO = 5'(LARGO - 1);

  localparam logic [2:0] N_G4 = 3'd0;
  localparam logic [2:0] N_A4 = 3'd1;
  localparam logic [2:0] N_B4 = 3'd2;
  localparam logic [2:0] N_C5 = 3'd3;
  localparam logic [2:0] N_D5 = 3'd4;
  localparam logic [2:0] N_E5 = 3'd5;
  localparam logic [2:0] N_F5 = 3'd6;
  localparam logic [2:0] N_G5 = 3'd7;

  localparam logic [2:0] NOTA [25] = '{
    N_G4, N_G4, N_A4, N_G4, N_C5, N_B4,
    N_G4, N_G4, N_A4, N_G4, N_D5, N_C5,
    N_G4, N_G4, N_G5, N_E5, N_C5, N_B4, N_A4,
    N_F5, N_F5, N_E5, N_C5, N_D5, N_C5
  };

  localparam logic [2:0] DUR [25] = '{
    3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd4,
    3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd4,
    3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd4,
    3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd4
  };

  // Half-period in clk_divisor cycles for each pitch code.
  function automatic logic [13:0] medio_de(input logic [2:0] n);
    case (n)
      N_G4:    medio_de = 14'd15306;
      N_A4:    medio_de = 14'd13636;
      N_B4:    medio_de = 14'd12148;
      N_C5:    medio_de = 14'd11467;
      N_D5:    medio_de = 14'd10215;
      N_E5:    medio_de = 14'd9101;
      N_F5:    medio_de = 14'd8590;
      default: medio_de = 14'd7653;
    endcase
  endfunction

  logic        q1, q2, tick;
  logic [1:0]  estado;
  logic [2:0]  restante;
  logic [13:0] cuenta;
  logic [13:0] medio;
  logic [4:0]  indice_sig;

  assign tick       = q1 ^ q2;
  assign medio      = medio_de(NOTA[indice_nota]);
  assign indice_sig = (indice_nota == ULTIMO) ? 5'd0 : indice_nota + 5'd1;

  always_ff @(posedge clk_divisor or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      q1 <= cambiar_nota;
      q2 <= q1;
    end
  end

  always_ff @(posedge clk_divisor or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= REPOSO;
      indice_nota <= 5'd0;
      restante    <= 3'd0;
      cuenta      <= 14'd0;
      parlante    <= 1'b0;
      sonando     <= 1'b0;
      fin_cancion <= 1'b0;
    end else begin
      case (estado)
        REPOSO, FIN: begin
          // A tick arriving together with iniciar is dropped: note 0 gets its full duration.
          if (iniciar) begin
            estado      <= SONANDO;
            indice_nota <= 5'd0;
            restante    <= DUR[0];
            cuenta      <= 14'd0;
            parlante    <= 1'b0;
            sonando     <= 1'b1;
            fin_cancion <= 1'b0;
          end
        end
        SONANDO: begin
          if (tick && restante == 3'd1) begin
            estado   <= PAUSA;
            cuenta   <= 14'd0;
            parlante <= 1'b0;
            sonando  <= 1'b0;
          end else begin
            if (tick) restante <= restante - 3'd1;
            if (cuenta == medio - 14'd1) begin
              cuenta   <= 14'd0;
              parlante <= ~parlante;
            end else begin
              cuenta <= cuenta + 14'd1;
            end
          end
        end
        PAUSA: begin
          if (tick) begin
            if (indice_nota == ULTIMO && !REPETIR) begin
              estado      <= FIN;
              fin_cancion <= 1'b1;
            end else begin
              estado      <= SONANDO;
              indice_nota <= indice_sig;
              restante    <= DUR[indice_sig];
              cuenta      <= 14'd0;
              parlante    <= 1'b0;
              sonando     <= 1'b1;
            end
          end
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_de_notas.sv
// Bench for secuenciador_de_notas: a song-timeline reference model checked every cycle,
// a table of early-song vectors, and directed sequences for reset, restart and tick timing.
module tb_secuenciador_de_notas;

  logic       clk_divisor = 1'b0;
  logic       rst_n = 1'b0;
  logic       cambiar_nota = 1'b0;
  logic       iniciar = 1'b0;
  logic       par0, son0, fin0, par1, son1, fin1;
  logic [4:0] idx0, idx1;

  always #5 clk_divisor = ~clk_divisor;

  secuenciador_de_notas #(.LARGO(25), .REPETIR(1'b0)) dut0 (
    .clk_divisor(clk_divisor), .rst_n(rst_n), .cambiar_nota(cambiar_nota),
    .iniciar(iniciar), .parlante(par0), .indice_nota(idx0), .sonando(son0),
    .fin_cancion(fin0)
  );

  secuenciador_de_notas #(.LARGO(25), .REPETIR(1'b1)) dut1 (
    .clk_divisor(clk_divisor), .rst_n(rst_n), .cambiar_nota(cambiar_nota),
    .iniciar(iniciar), .parlante(par1), .indice_nota(idx1), .sonando(son1),
    .fin_cancion(fin1)
  );

  int checks = 0;
  int failures = 0;

  int dur_tab[25] = '{1,1,2,2,2,4, 1,1,2,2,2,4, 1,1,2,2,2,2,4, 1,1,2,2,2,4};
  int medio_tab[25] = '{15306,15306,13636,15306,11467,12148,
                        15306,15306,13636,15306,10215,11467,
                        15306,15306,7653,9101,11467,12148,13636,
                        8590,8590,9101,11467,10215,11467};

  // Song timeline: one entry per tick slot (note index, sounding or gap).
  int seq_nota[75];
  bit seq_snd[75];

  // Model per instance: started flag, ticks since start, cycles since segment start.
  bit st[2];
  int p[2];
  int c[2];
  bit tog_prev = 1'b0;

  function automatic bit fin_m(int r);
    return st[r] && r == 0 && p[r] >= 75;
  endfunction

  function automatic int seg(int r);
    int pos;
    if (fin_m(r)) return -1;
    pos = p[r] % 75;
    return seq_nota[pos] * 2 + int'(seq_snd[pos]);
  endfunction

  function automatic int e_idx(int r);
    if (!st[r]) return 0;
    if (fin_m(r)) return 24;
    return seq_nota[p[r] % 75];
  endfunction

  function automatic int e_son(int r);
    if (!st[r] || fin_m(r)) return 0;
    return int'(seq_snd[p[r] % 75]);
  endfunction

  function automatic int e_fin(int r);
    return fin_m(r) ? 1 : 0;
  endfunction

  function automatic int e_par(int r);
    if (e_son(r) == 0) return 0;
    return ((c[r] / medio_tab[e_idx(r)]) % 2 == 1) ? 1 : 0;
  endfunction

  task automatic model_edge(input bit ini, input bit tk);
    int o;
    for (int r = 0; r < 2; r++) begin
      if (ini && (!st[r] || fin_m(r))) begin
        st[r] = 1'b1;
        p[r] = 0;
        c[r] = 0;
      end else if (st[r] && !fin_m(r)) begin
        o = seg(r);
        if (tk) p[r]++;
        if (seg(r) != o) c[r] = 0;
        else c[r]++;
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("idx0", int'(idx0), e_idx(0));
    chk("son0", int'(son0), e_son(0));
    chk("fin0", int'(fin0), e_fin(0));
    chk("par0", int'(par0), e_par(0));
    chk("idx1", int'(idx1), e_idx(1));
    chk("son1", int'(son1), e_son(1));
    chk("fin1", int'(fin1), e_fin(1));
    chk("par1", int'(par1), e_par(1));
  endtask

  // One clock cycle: drive inputs mid-cycle, advance the model at the edge, compare after it.
  // A toggle driven before edge e is seen as a tick by the FSM at edge e+1.
  task automatic cyc(input bit tog, input bit ini);
    @(negedge clk_divisor);
    if (tog) cambiar_nota = ~cambiar_nota;
    iniciar = ini;
    @(posedge clk_divisor);
    model_edge(ini, tog_prev);
    tog_prev = tog;
    #1;
    compare_all();
  endtask

  task automatic reset_mid(input string nm);
    @(negedge clk_divisor);
    #2 rst_n = 1'b0;
    #1;
    chk({nm, "_par0"}, int'(par0), 0);
    chk({nm, "_son0"}, int'(son0), 0);
    chk({nm, "_fin0"}, int'(fin0), 0);
    chk({nm, "_idx0"}, int'(idx0), 0);
    chk({nm, "_par1"}, int'(par1), 0);
    chk({nm, "_son1"}, int'(son1), 0);
    chk({nm, "_idx1"}, int'(idx1), 0);
    cambiar_nota = 1'b0;
    iniciar = 1'b0;
    tog_prev = 1'b0;
    st[0] = 1'b0;
    st[1] = 1'b0;
    @(negedge clk_divisor);
    rst_n = 1'b1;
    repeat (5) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
    end
    chk({nm, "_idle_son0"}, int'(son0), 0);
    chk({nm, "_idle_idx0"}, int'(idx0), 0);
  endtask

  typedef struct {
    bit tog;
    bit ini;
    int idx;
    bit son;
    bit fin;
  } vec_t;

  vec_t tabla[8];

  initial begin
    int k;
    int gap;
    bit ri;

    tabla[0] = '{tog: 1'b1, ini: 1'b0, idx: 0, son: 1'b0, fin: 1'b0};
    tabla[1] = '{tog: 1'b1, ini: 1'b0, idx: 1, son: 1'b1, fin: 1'b0};
    tabla[2] = '{tog: 1'b1, ini: 1'b0, idx: 1, son: 1'b0, fin: 1'b0};
    tabla[3] = '{tog: 1'b1, ini: 1'b0, idx: 2, son: 1'b1, fin: 1'b0};
    tabla[4] = '{tog: 1'b0, ini: 1'b1, idx: 2, son: 1'b1, fin: 1'b0};
    tabla[5] = '{tog: 1'b1, ini: 1'b0, idx: 2, son: 1'b1, fin: 1'b0};
    tabla[6] = '{tog: 1'b1, ini: 1'b0, idx: 2, son: 1'b0, fin: 1'b0};
    tabla[7] = '{tog: 1'b1, ini: 1'b0, idx: 3, son: 1'b1, fin: 1'b0};

    k = 0;
    for (int n = 0; n < 25; n++) begin
      for (int d = 0; d < dur_tab[n]; d++) begin
        seq_nota[k] = n;
        seq_snd[k] = 1'b1;
        k++;
      end
      seq_nota[k] = n;
      seq_snd[k] = 1'b0;
      k++;
    end
    st[0] = 1'b0;
    st[1] = 1'b0;

    repeat (3) @(posedge clk_divisor);
    #1;
    chk("rst_par", int'(par0), 0);
    chk("rst_son", int'(son0), 0);
    chk("rst_fin", int'(fin0), 0);
    chk("rst_idx", int'(idx0), 0);
    @(negedge clk_divisor);
    rst_n = 1'b1;

    repeat (10) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
    end
    chk("reposo_ignores_tick", int'(son0), 0);

    // G4 tone: first rise exactly medio cycles after start, then async reset mid-tone.
    cyc(1'b0, 1'b1);
    chk("start_son", int'(son0), 1);
    chk("start_idx", int'(idx0), 0);
    repeat (15305) cyc(1'b0, 1'b0);
    chk("tone_before_rise", int'(par0), 0);
    cyc(1'b0, 1'b0);
    chk("tone_rise", int'(par0), 1);
    reset_mid("reset_mid_tone");

    cyc(1'b0, 1'b1);
    repeat (30611) cyc(1'b0, 1'b0);
    chk("tone_before_fall", int'(par0), 1);
    cyc(1'b0, 1'b0);
    chk("tone_fall", int'(par0), 0);

    for (int i = 0; i < 8; i++) begin
      cyc(tabla[i].tog, tabla[i].ini);
      repeat (99) cyc(1'b0, 1'b0);
      chk($sformatf("tabla%0d_idx", i), int'(idx0), tabla[i].idx);
      chk($sformatf("tabla%0d_son", i), int'(son0), int'(tabla[i].son));
      chk($sformatf("tabla%0d_fin", i), int'(fin0), int'(tabla[i].fin));
      chk($sformatf("tabla%0d_par", i), int'(par0), 0);
    end

    // Rest of the song with random tick spacing and stray iniciar pulses.
    while (p[0] < 75) begin
      if (p[0] == 13) begin
        cyc(1'b0, 1'b1);
        chk("ini_nota5_idx", int'(idx0), 5);
        chk("ini_nota5_son", int'(son0), 1);
      end
      gap = (p[0] == 40) ? 15400 : int'($urandom_range(2, 200));
      cyc(1'b1, 1'b0);
      for (int g = 1; g < gap; g++) begin
        ri = (p[0] < 74) && ($urandom_range(0, 31) == 0);
        cyc(1'b0, ri);
      end
    end
    chk("fin_flag", int'(fin0), 1);
    chk("fin_idx", int'(idx0), 24);
    chk("fin_par", int'(par0), 0);
    chk("fin_son", int'(son0), 0);
    chk("rep_fin", int'(fin1), 0);
    chk("rep_idx", int'(idx1), 0);
    chk("rep_son", int'(son1), 1);

    // Start and tick on the same edge from FIN: start wins, note 0 still needs one tick.
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    chk("restart_son", int'(son0), 1);
    chk("restart_idx", int'(idx0), 0);
    chk("restart_fin", int'(fin0), 0);
    repeat (10) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("restart_one_tick_son", int'(son0), 0);
    chk("restart_one_tick_idx", int'(idx0), 0);

    // Two toggles one cycle apart are two ticks.
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("double_tick_idx", int'(idx0), 1);
    chk("double_tick_son", int'(son0), 0);

    // Tick latency: no effect on the edge that samples the toggle, effect on the next.
    cyc(1'b1, 1'b0);
    chk("latency_early_idx", int'(idx0), 1);
    chk("latency_early_son", int'(son0), 0);
    cyc(1'b0, 1'b0);
    chk("latency_idx", int'(idx0), 2);
    chk("latency_son", int'(son0), 1);

    reset_mid("reset_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
